// File: rtl/pythag_leg_solver.sv
// pythag_leg_solver
//   Given hypotenuse R and one leg X, computes the other leg
//   Y = floor(sqrt(R*R - X*X)) with an MSB-first bit-serial square root,
//   one result bit per enabled clock. If X > R, there is no real result,
//   and err is flagged instead.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   ena        in   clock enable; when low, all state holds
//   in_valid   in   r_in/x_in valid
//   in_ready   out  block can accept operands (IDLE and ena)
//   r_in       in   [W-1:0] hypotenuse R, unsigned
//   x_in       in   [W-1:0] known leg X, unsigned
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   y_out      out  [W-1:0] computed leg Y
//   err        out  X > R, y_out forced to 0
module pythag_leg_solver #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] x_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y_out,
  output logic         err
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROOT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2*W-1:0] r_diff;
  logic [W-1:0]   r_result;
  logic [KW-1:0]  r_k;
  logic [W-1:0]   r_y;
  logic           r_err;

  // Operand squares are formed at full 2W width so that nothing truncates.
  logic [2*W-1:0] w_r_sq;
  logic [2*W-1:0] w_x_sq;
  logic [2*W-1:0] w_diff;
  logic           w_x_gt_r;
  logic           w_accept;
  logic           w_out_hs;

  logic [W-1:0]   w_bit;
  logic [W-1:0]   w_trial;
  logic [2*W-1:0] w_trial_sq;
  logic [W-1:0]   w_result_next;

  assign w_r_sq   = {{W{1'b0}}, r_in} * {{W{1'b0}}, r_in};
  assign w_x_sq   = {{W{1'b0}}, x_in} * {{W{1'b0}}, x_in};
  // When X > R, this value wraps, but it is never used because that path goes
  // straight to DONE with err set.
  assign w_diff   = w_r_sq - w_x_sq;
  assign w_x_gt_r = (x_in > r_in);

  // in_ready is also masked by rst, so it reads 0 during reset even though
  // the state register already sits in IDLE.
  assign in_ready  = (r_state == S_IDLE) && ena && !rst;
  assign out_valid = (r_state == S_DONE);
  assign y_out     = r_y;
  assign err       = r_err;

  assign w_accept = ena && in_valid && (r_state == S_IDLE);
  assign w_out_hs = ena && out_ready && (r_state == S_DONE);

  // One square-root step: tentatively set bit k and keep it if the square
  // still fits under the difference.
  assign w_bit         = {{(W-1){1'b0}}, 1'b1} << r_k;
  assign w_trial       = r_result | w_bit;
  assign w_trial_sq    = {{W{1'b0}}, w_trial} * {{W{1'b0}}, w_trial};
  assign w_result_next = (w_trial_sq <= r_diff) ? w_trial : r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_x_gt_r ? S_DONE : S_ROOT;
        end
      end
      S_ROOT: begin
        if (r_k == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_out_hs) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff   <= '0;
      r_result <= '0;
      r_k      <= '0;
      r_y      <= '0;
      r_err    <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_diff   <= w_diff;
            r_result <= '0;
            r_k      <= KW'(W - 1);
            if (w_x_gt_r) begin
              r_err <= 1'b1;
              r_y   <= '0;
            end
          end
        end
        S_ROOT: begin
          r_result <= w_result_next;
          if (r_k == '0) begin
            r_y   <= w_result_next;
            r_err <= 1'b0;
          end else begin
            r_k <= r_k - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pythag_leg_solver.sv
module tb_pythag_leg_solver;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] r_in;
  logic [W-1:0] x_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y_out;
  logic         err;

  int n_cmp;
  int n_fail;

  pythag_leg_solver #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for out_valid, counting edges since the accept edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 50);
  endtask

  task automatic accept(input logic [W-1:0] r, input logic [W-1:0] x, input string tag);
    @(negedge clk);
    r_in = r;
    x_in = x;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    r_in = 8'hA5;  // operands need only be stable at the accept edge
    x_in = 8'h5A;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, int'(out_valid), 0);
    chk({tag, "_ir_back"}, int'(in_ready), 1);
  endtask

  task automatic run_op(input logic [W-1:0] r, input logic [W-1:0] x,
                        input int y_exp, input int err_exp, input int lat_exp,
                        input string tag);
    int lat;
    accept(r, x, tag);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, lat_exp);
    chk({tag, "_y"}, int'(y_out), y_exp);
    chk({tag, "_err"}, int'(err), err_exp);
    $display("op %s: R=%0d X=%0d -> y=%0d err=%0d lat=%0d", tag, r, x, y_out, err, lat);
    handshake(tag);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    ena = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    r_in = '0;
    x_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y_out), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);

    // Main function and boundaries
    run_op(8'd5,   8'd3,   4,   0, 8, "r5x3");
    run_op(8'd13,  8'd12,  5,   0, 8, "r13x12");
    run_op(8'd200, 8'd100, 173, 0, 8, "r200x100");
    run_op(8'd255, 8'd0,   255, 0, 8, "r255x0");
    run_op(8'd7,   8'd7,   0,   0, 8, "r7x7");
    run_op(8'd0,   8'd0,   0,   0, 8, "r0x0");
    run_op(8'd10,  8'd11,  0,   1, 1, "r10x11");
    run_op(8'd9,   8'd0,   9,   0, 8, "r9x0");  // clears err after error result

    // Backpressure: hold out_ready low for 5 cycles, new in_valid is ignored
    accept(8'd200, 8'd100, "hold");
    wait_valid(lat);
    chk("hold_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      r_in = 8'd9;
      x_in = 8'd3;
      @(posedge clk);
      #1;
      chk("hold_ov", int'(out_valid), 1);
      chk("hold_y", int'(y_out), 173);
      chk("hold_err", int'(err), 0);
      chk("hold_ir", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    $display("op hold: y=%0d held 5 cycles", y_out);
    handshake("hold");
    @(negedge clk);
    chk("hold_no_queue", int'(out_valid), 0);

    // ena low for 3 cycles mid-ROOT extends latency by exactly 3
    accept(8'd13, 8'd12, "ena");
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b0;
    chk("ena_low_ir", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b1;
    lat = 6;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 50);
    chk("ena_lat", lat, 11);
    chk("ena_y", int'(y_out), 5);
    chk("ena_err", int'(err), 0);
    // With ena low, the output handshake must not complete.
    ena = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ena_done_hold", int'(out_valid), 1);
    ena = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ena_done_drop", int'(out_valid), 0);
    $display("op ena: y=%0d lat=%0d", y_out, lat);

    // Asynchronous reset at iteration 4 of R=100, X=60
    accept(8'd100, 8'd60, "arst");
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", int'(out_valid), 0);
    chk("arst_y", int'(y_out), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_ir", int'(in_ready), 0);
    $display("op arst: reset mid-ROOT, y=%0d", y_out);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd100, 8'd60, 80, 0, 8, "r100x60");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
